hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter MEM_LAT, default 1, meaning data-memory cycles per access (1..8).
REQ-003 The block SHALL have parameter FWD_EN, default 1, meaning 1 selects forwarding and 0 selects stall-on-RAW.
REQ-004 The block SHALL have parameter CNT_W, default 32, meaning statistics counter width.
REQ-005 Ports (name, direction, width, meaning):
 clk  in  1  single clock, rising edge
 rst  in  1  reset, asynchronous, active-low
 rs1D, rs2D  in  REG_AW  D-stage source registers
 useRs1D, useRs2D  in  1  D-stage instruction reads that source
 rs1E, rs2E, rdE  in  REG_AW  E-stage sources and destination
 regWriteE, isLoadE  in  1  E-stage writes RF; E-stage is a load
 rdM  in  REG_AW  M-stage destination
 regWriteM, memReqM  in  1  M-stage writes RF; M-stage accesses data memory
 rdW  in  REG_AW  W-stage destination
 regWriteW  in  1  W-stage writes RF
 PCSrcE  in  1  taken branch or jump resolved in E
 clrStats  in  1  synchronous clear of statistics counters
 stallF, stallD, stallE, stallM  out  1  hold the PC or the named pipeline register
 flushD, flushE, flushW  out  1  clear the named pipeline register to a bubble
 forwardAE, forwardBE  out  2  E operand select: 00 RF, 01 W result, 10 M result
 stallCount, flushCount  out  CNT_W  statistics

Function
REQ-006 forwardAE SHALL be 10 if regWriteM, rdM!=0 and rdM==rs1E; otherwise 01 if regWriteW, rdW!=0 and rdW==rs1E; otherwise 00. forwardBE SHALL follow the same rule using rs2E.
REQ-007 Register x0 SHALL never cause forwarding or a stall.
REQ-008 With FWD_EN=0, forwardAE/BE SHALL be 00, and any used D source matching a writing rdE, rdM or rdW SHALL assert stallF, stallD and flushE.
REQ-009 Load-use: isLoadE, rdE!=0 and rdE matching a used D source SHALL assert stallF, stallD and flushE for exactly one cycle.
REQ-010 PCSrcE SHALL assert flushD and flushE in the same cycle and SHALL suppress the REQ-008/009 stalls.
REQ-011 Memory wait FSM, states IDLE and WAIT, 3-bit down-counter cnt: with MEM_LAT=1 the FSM SHALL stay in IDLE.
REQ-012 In IDLE with memReqM=1 and MEM_LAT>=2, the block SHALL assert stallF/D/E/M and flushW. If MEM_LAT>2 it SHALL load cnt=MEM_LAT-2 and go to WAIT; otherwise it SHALL stay in IDLE. In this case IDLE is re-entered with a new M instruction.
REQ-013 In WAIT, the block SHALL assert stallF/D/E/M and flushW while cnt!=0 and decrement cnt. At cnt==0 it SHALL deassert all stalls and return to IDLE. Each access therefore costs exactly MEM_LAT-1 stall cycles.
REQ-014 Priority SHALL be memory wait over PCSrcE over load-use/RAW. While a memory stall is active, flushD and flushE SHALL be 0.
REQ-015 Memory ops on back-to-back M instructions SHALL each incur their own wait.
REQ-016 stallCount SHALL increment in every cycle with stallF=1. flushCount SHALL increment in every cycle with flushD=1. Both SHALL saturate at all-ones.
REQ-017 clrStats SHALL zero both counters next edge. When it coincides with an increment, the clear SHALL win.
REQ-018 All stall, flush and forward outputs SHALL be combinational from inputs and state, with zero latency.

Reset
REQ-019 rst low SHALL immediately force state IDLE, cnt=0, stallCount=0 and flushCount=0.
REQ-020 While rst is low, all stall, flush and forward outputs SHALL read 0.
REQ-021 Reset asserted mid-WAIT SHALL abandon the wait. After release, the FSM SHALL start from IDLE.

Structure
REQ-022 Shared package hazard_pkg SHALL hold the forward-select encodings (FWD_RF, FWD_W, FWD_M) and the FSM state type.
REQ-023 Sub-module sat_counter (CNT_W, inc, clr) SHALL be instantiated twice, once per statistics counter.

Verification
REQ-024 Scenario 1: rdM=5, regWriteM=1, rdW=5, regWriteW=1, rs1E=5 -> forwardAE=10. Same with rdM=0 -> forwardAE=01.
REQ-025 Scenario 2: isLoadE=1, rdE=7, rs2D=7, useRs2D=1 -> stallF, stallD and flushE high for one cycle; stallCount +1.
REQ-026 Scenario 3: load-use of REQ-025 plus PCSrcE=1 -> flushD=flushE=1, stallF=0; flushCount +1.
REQ-027 Scenario 4: MEM_LAT=4, memReqM pulse -> stallF/D/E/M and flushW high exactly 3 cycles; PCSrcE=1 during them gives flushD=0.
REQ-028 Scenario 5: FWD_EN=0, regWriteW=1, rdW=3, rs1D=3, useRs1D=1 -> stall; same with rd=0 -> no stall.
REQ-029 Scenario 6: CNT_W=4, 20 stall cycles -> stallCount=15; rst low mid-WAIT -> outputs 0 and FSM IDLE after release.

Source files
------------

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types for the pipeline hazard controller.
//   fwdSel_t   : E-stage operand source select (register file, W result,
//                M result). The encodings are visible on forwardAE/forwardBE.
//   memState_t : state of the data-memory wait sequencer.
//   MEM_CNT_W  : width of the memory wait down-counter.
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwdSel_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } memState_t;

  localparam int MEM_CNT_W = 3;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Pipeline-side signal bundle of the hazard controller.
//   master : the pipeline. Drives stage register addresses and control bits,
//            receives stall, flush and forward controls.
//   slave  : the hazard controller.
// Parameter REG_AW : register address width.
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);

  // Decode stage
  logic [REG_AW-1:0] rs1D;
  logic [REG_AW-1:0] rs2D;
  logic              useRs1D;
  logic              useRs2D;
  // Execute stage
  logic [REG_AW-1:0] rs1E;
  logic [REG_AW-1:0] rs2E;
  logic [REG_AW-1:0] rdE;
  logic              regWriteE;
  logic              isLoadE;
  logic              PCSrcE;
  // Memory stage
  logic [REG_AW-1:0] rdM;
  logic              regWriteM;
  logic              memReqM;
  // Writeback stage
  logic [REG_AW-1:0] rdW;
  logic              regWriteW;
  // Controls back to the pipeline
  logic              stallF;
  logic              stallD;
  logic              stallE;
  logic              stallM;
  logic              flushD;
  logic              flushE;
  logic              flushW;
  logic [1:0]        forwardAE;
  logic [1:0]        forwardBE;

  modport master (
    output rs1D, rs2D, useRs1D, useRs2D,
    output rs1E, rs2E, rdE, regWriteE, isLoadE, PCSrcE,
    output rdM, regWriteM, memReqM,
    output rdW, regWriteW,
    input  stallF, stallD, stallE, stallM,
    input  flushD, flushE, flushW,
    input  forwardAE, forwardBE
  );

  modport slave (
    input  rs1D, rs2D, useRs1D, useRs2D,
    input  rs1E, rs2E, rdE, regWriteE, isLoadE, PCSrcE,
    input  rdM, regWriteM, memReqM,
    input  rdW, regWriteW,
    output stallF, stallD, stallE, stallM,
    output flushD, flushE, flushW,
    output forwardAE, forwardBE
  );

endinterface

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating event counter with synchronous clear.
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active low, clears the count
//   inc   : count one event this cycle
//   clr   : zero the count at the next edge; takes priority over inc
//   count : current value, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard unit for a five-stage pipeline: operand forwarding, load-use and
// RAW stalls, branch flushes, a data-memory wait sequencer and stall/flush
// statistics.
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   hz         : pipeline bundle (hazard_ctrl_if.slave)
//   clrStats   : synchronous clear of both statistics counters
//   stallCount : cycles with stallF asserted (saturating)
//   flushCount : cycles with flushD asserted (saturating)
// Parameters: REG_AW register address width, MEM_LAT data-memory cycles per
// access (1..8), FWD_EN 1 = forwarding / 0 = stall on RAW, CNT_W counter width.
// ---------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     hz,
  input  logic             clrStats,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  // A producer matches a consumer only when it really writes, the source is
  // really read, and the register is not x0.
  function automatic logic regHit(
    input logic [REG_AW-1:0] rs,
    input logic              useRs,
    input logic [REG_AW-1:0] rd,
    input logic              writes
  );
    return useRs && writes && (rd != '0) && (rd == rs);
  endfunction

  // M result is the newer value, so it beats the W result.
  function automatic fwdSel_t fwdSel(input logic [REG_AW-1:0] rs);
    if (regHit(rs, 1'b1, hz.rdM, hz.regWriteM)) begin
      return FWD_M;
    end else if (regHit(rs, 1'b1, hz.rdW, hz.regWriteW)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  memState_t            state;
  logic [MEM_CNT_W-1:0] cnt;
  // Set after the single stall cycle of a two-cycle access: the M stage still
  // holds that same instruction for one more cycle and must not stall again.
  logic                 holdDone;
  logic                 memStall;
  logic                 loadUse;
  logic                 rawStall;

  // ---------------------------------------------------------------------
  // Memory wait sequencer
  // ---------------------------------------------------------------------
  always_comb begin
    memStall = 1'b0;
    if (MEM_LAT >= 2) begin
      case (state)
        IDLE:    memStall = hz.memReqM && !holdDone;
        WAIT:    memStall = (cnt != '0);
        default: memStall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      holdDone <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          holdDone <= 1'b0;
          if (memStall) begin
            if (MEM_LAT > 2) begin
              // First stall cycle is spent here; WAIT covers the rest.
              cnt   <= MEM_CNT_W'(MEM_LAT - 2);
              state <= WAIT;
            end else begin
              holdDone <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Data hazards
  // ---------------------------------------------------------------------
  assign loadUse = regHit(hz.rs1D, hz.useRs1D, hz.rdE, hz.isLoadE)
                || regHit(hz.rs2D, hz.useRs2D, hz.rdE, hz.isLoadE);

  // Without forwarding any in-flight writer of a used source holds decode.
  assign rawStall = (FWD_EN == 0) && (
                      regHit(hz.rs1D, hz.useRs1D, hz.rdE, hz.regWriteE)
                   || regHit(hz.rs2D, hz.useRs2D, hz.rdE, hz.regWriteE)
                   || regHit(hz.rs1D, hz.useRs1D, hz.rdM, hz.regWriteM)
                   || regHit(hz.rs2D, hz.useRs2D, hz.rdM, hz.regWriteM)
                   || regHit(hz.rs1D, hz.useRs1D, hz.rdW, hz.regWriteW)
                   || regHit(hz.rs2D, hz.useRs2D, hz.rdW, hz.regWriteW));

  // ---------------------------------------------------------------------
  // Control outputs: memory wait > taken branch > load-use / RAW.
  // Everything reads 0 while reset is held.
  // ---------------------------------------------------------------------
  always_comb begin
    hz.stallF    = 1'b0;
    hz.stallD    = 1'b0;
    hz.stallE    = 1'b0;
    hz.stallM    = 1'b0;
    hz.flushD    = 1'b0;
    hz.flushE    = 1'b0;
    hz.flushW    = 1'b0;
    hz.forwardAE = FWD_RF;
    hz.forwardBE = FWD_RF;
    if (rst) begin
      if (FWD_EN != 0) begin
        hz.forwardAE = fwdSel(hz.rs1E);
        hz.forwardBE = fwdSel(hz.rs2E);
      end
      if (memStall) begin
        // Whole pipe freezes; W gets a bubble since M produces nothing yet.
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.stallE = 1'b1;
        hz.stallM = 1'b1;
        hz.flushW = 1'b1;
      end else if (hz.PCSrcE) begin
        // The wrong-path instruction in D is discarded, so any hazard it
        // raised is moot.
        hz.flushD = 1'b1;
        hz.flushE = 1'b1;
      end else if (loadUse || rawStall) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.flushE = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------
  sat_counter #(.CNT_W(CNT_W)) stallCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hz.stallF),
    .clr   (clrStats),
    .count (stallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) flushCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hz.flushD),
    .clr   (clrStats),
    .count (flushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Two instances share stimulus: dutA (forwarding, MEM_LAT=4, CNT_W=4) and
// dutB (stall-on-RAW, MEM_LAT=2, CNT_W=8). Combinational behaviour is checked
// from vector tables; counters, memory waits and reset are hand sequences.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clrStats;
  logic [3:0] stallCntA, flushCntA;
  logic [7:0] stallCntB, flushCntB;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5)) ifA ();
  hazard_ctrl_if #(.REG_AW(5)) ifB ();

  hazard_ctrl #(.REG_AW(5), .MEM_LAT(4), .FWD_EN(1), .CNT_W(4)) dutA (
    .clk(clk), .rst(rst), .hz(ifA), .clrStats(clrStats),
    .stallCount(stallCntA), .flushCount(flushCntA)
  );

  hazard_ctrl #(.REG_AW(5), .MEM_LAT(2), .FWD_EN(0), .CNT_W(8)) dutB (
    .clk(clk), .rst(rst), .hz(ifB), .clrStats(clrStats),
    .stallCount(stallCntB), .flushCount(flushCntB)
  );

  // flags = {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
  typedef struct {
    logic [4:0] rs1D, rs2D;
    logic       useRs1D, useRs2D;
    logic [4:0] rs1E, rs2E, rdE;
    logic       regWriteE, isLoadE;
    logic [4:0] rdM;
    logic       regWriteM;
    logic [4:0] rdW;
    logic       regWriteW, pcSrc;
    logic [6:0] flags;
    logic [1:0] fwdA, fwdB;
  } vec_t;

  vec_t vecA[12];
  vec_t vecB[7];
  vec_t idleV;
  vec_t v;

  function automatic vec_t mk(int r1D, int r2D, int u1, int u2, int r1E, int r2E,
                              int dE, int wE, int ld, int dM, int wM, int dW,
                              int wW, int pc, int fl, int fa, int fb);
    vec_t t;
    t.rs1D = 5'(r1D); t.rs2D = 5'(r2D); t.useRs1D = 1'(u1); t.useRs2D = 1'(u2);
    t.rs1E = 5'(r1E); t.rs2E = 5'(r2E); t.rdE = 5'(dE);
    t.regWriteE = 1'(wE); t.isLoadE = 1'(ld);
    t.rdM = 5'(dM); t.regWriteM = 1'(wM);
    t.rdW = 5'(dW); t.regWriteW = 1'(wW); t.pcSrc = 1'(pc);
    t.flags = 7'(fl); t.fwdA = 2'(fa); t.fwdB = 2'(fb);
    return t;
  endfunction

  task automatic drive(input vec_t t, input logic memReq);
    ifA.rs1D = t.rs1D; ifA.rs2D = t.rs2D; ifA.useRs1D = t.useRs1D; ifA.useRs2D = t.useRs2D;
    ifA.rs1E = t.rs1E; ifA.rs2E = t.rs2E; ifA.rdE = t.rdE;
    ifA.regWriteE = t.regWriteE; ifA.isLoadE = t.isLoadE; ifA.PCSrcE = t.pcSrc;
    ifA.rdM = t.rdM; ifA.regWriteM = t.regWriteM; ifA.memReqM = memReq;
    ifA.rdW = t.rdW; ifA.regWriteW = t.regWriteW;
    ifB.rs1D = t.rs1D; ifB.rs2D = t.rs2D; ifB.useRs1D = t.useRs1D; ifB.useRs2D = t.useRs2D;
    ifB.rs1E = t.rs1E; ifB.rs2E = t.rs2E; ifB.rdE = t.rdE;
    ifB.regWriteE = t.regWriteE; ifB.isLoadE = t.isLoadE; ifB.PCSrcE = t.pcSrc;
    ifB.rdM = t.rdM; ifB.regWriteM = t.regWriteM; ifB.memReqM = memReq;
    ifB.rdW = t.rdW; ifB.regWriteW = t.regWriteW;
  endtask

  function automatic logic [6:0] flagsA();
    return {ifA.stallF, ifA.stallD, ifA.stallE, ifA.stallM, ifA.flushD, ifA.flushE, ifA.flushW};
  endfunction

  function automatic logic [6:0] flagsB();
    return {ifB.stallF, ifB.stallD, ifB.stallE, ifB.stallM, ifB.flushD, ifB.flushE, ifB.flushW};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  // One stats-clear cycle; ends on a negedge with idle inputs.
  task automatic clearStats();
    @(negedge clk); drive(idleV, 1'b0); clrStats = 1'b1;
    @(negedge clk); clrStats = 1'b0;
  endtask

  initial begin
    // flags: 7'b1100010 = stallF|stallD|flushE, 7'b0000110 = flushD|flushE
    idleV   = mk(0,0,0,0, 0,0,0,0,0, 0,0, 0,0, 0, 0, 0,0);
    vecA[0]  = idleV;
    vecA[1]  = mk(0,0,0,0, 5,0,0,0,0, 5,1, 5,1, 0, 0, 2,0);            // M beats W
    vecA[2]  = mk(0,0,0,0, 5,0,0,0,0, 0,1, 5,1, 0, 0, 1,0);            // rdM=x0 -> W
    vecA[3]  = mk(0,0,0,0, 0,9,0,0,0, 9,0, 9,1, 0, 0, 0,1);            // M not writing
    vecA[4]  = mk(0,0,0,0, 0,0,0,0,0, 0,1, 0,1, 0, 0, 0,0);            // x0 everywhere
    vecA[5]  = mk(0,0,0,0, 3,3,0,0,0, 3,1, 8,1, 0, 0, 2,2);            // both operands
    vecA[6]  = mk(0,7,0,1, 0,0,7,1,1, 0,0, 0,0, 0, 7'b1100010, 0,0);   // load-use rs2
    vecA[7]  = mk(0,7,0,0, 0,0,7,1,1, 0,0, 0,0, 0, 0, 0,0);            // source unused
    vecA[8]  = mk(0,0,1,0, 0,0,0,1,1, 0,0, 0,0, 0, 0, 0,0);            // load to x0
    vecA[9]  = mk(0,7,0,1, 0,0,7,1,1, 0,0, 0,0, 1, 7'b0000110, 0,0);   // branch wins
    vecA[10] = mk(0,0,0,0, 0,0,0,0,0, 0,0, 0,0, 1, 7'b0000110, 0,0);   // branch alone
    vecA[11] = mk(4,0,1,0, 0,0,4,1,0, 0,0, 0,0, 0, 0, 0,0);            // ALU RAW forwarded
    vecB[0]  = mk(3,0,1,0, 3,0,0,0,0, 0,0, 3,1, 0, 7'b1100010, 0,0);   // W RAW, no forward
    vecB[1]  = mk(0,0,1,0, 0,0,0,0,0, 0,0, 0,1, 0, 0, 0,0);            // x0
    vecB[2]  = mk(0,6,0,1, 0,0,0,0,0, 6,1, 0,0, 0, 7'b1100010, 0,0);   // M RAW
    vecB[3]  = mk(2,0,1,0, 0,0,2,1,0, 0,0, 0,0, 0, 7'b1100010, 0,0);   // E RAW
    vecB[4]  = mk(2,0,0,0, 0,0,2,1,0, 0,0, 0,0, 0, 0, 0,0);            // source unused
    vecB[5]  = mk(2,0,1,0, 0,0,2,1,0, 0,0, 0,0, 1, 7'b0000110, 0,0);   // branch wins
    vecB[6]  = mk(0,6,0,1, 0,0,0,0,0, 6,0, 0,0, 0, 0, 0,0);            // M not writing

    // ---- reset state: hazards on the inputs, outputs must stay 0 ----
    rst = 1'b0; clrStats = 1'b0;
    drive(mk(0,7,0,1, 5,0,7,1,1, 5,1, 0,0, 0, 0, 0,0), 1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_flagsA", flagsA(), 0);
    chk("rst_fwdA", ifA.forwardAE, 0);
    chk("rst_flagsB", flagsB(), 0);
    chk("rst_stallCntA", stallCntA, 0);
    @(negedge clk); drive(idleV, 1'b0); rst = 1'b1;

    // ---- combinational table, forwarding instance ----
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); drive(vecA[i], 1'b0); #1;
      chk($sformatf("A%0d_flags", i), flagsA(), vecA[i].flags);
      chk($sformatf("A%0d_fwdA", i), ifA.forwardAE, vecA[i].fwdA);
      chk($sformatf("A%0d_fwdB", i), ifA.forwardBE, vecA[i].fwdB);
    end

    // ---- load-use lasts one cycle and counts once ----
    clearStats(); #1;
    chk("clr_stallCnt", stallCntA, 0);
    chk("clr_flushCnt", flushCntA, 0);
    drive(vecA[6], 1'b0); #1;
    chk("lu_stallF", ifA.stallF, 1);
    @(negedge clk); drive(idleV, 1'b0); #1;
    chk("lu_released", ifA.stallF, 0);
    chk("lu_stallCnt", stallCntA, 1);

    // ---- clear wins over a coincident increment ----
    @(negedge clk); drive(vecA[6], 1'b0); clrStats = 1'b1;
    @(negedge clk); drive(idleV, 1'b0); clrStats = 1'b0; #1;
    chk("clrwin_stallCnt", stallCntA, 0);

    // ---- load-use with taken branch ----
    @(negedge clk); drive(vecA[9], 1'b0); #1;
    chk("br_stallF", ifA.stallF, 0);
    chk("br_flushD", ifA.flushD, 1);
    @(negedge clk); drive(idleV, 1'b0); #1;
    chk("br_flushCnt", flushCntA, 1);
    chk("br_stallCnt", stallCntA, 0);

    // ---- single memory access, MEM_LAT=4, branch during the wait ----
    clearStats();
    begin
      logic expStall[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int c = 0; c < 5; c++) begin
        if (c > 0) begin
          @(negedge clk); v = idleV; v.pcSrc = 1'b1; drive(v, 1'b0);
        end else begin
          drive(idleV, 1'b1);
        end
        #1;
        chk($sformatf("mem%0d_stall", c), flagsA() & 7'b1111001,
            expStall[c] ? 7'b1111001 : 7'b0);
        chk($sformatf("mem%0d_flushD", c), ifA.flushD, (c > 0) && !expStall[c]);
      end
    end
    @(negedge clk); drive(idleV, 1'b0); #1;
    chk("mem_stallCnt", stallCntA, 3);
    chk("mem_flushCnt", flushCntA, 2);

    // ---- back-to-back memory instructions each wait ----
    clearStats();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      drive(idleV, 1'b1); #1;
      chk($sformatf("b2b%0d_stallM", c), ifA.stallM, (c % 4) != 3);
    end
    @(negedge clk); drive(idleV, 1'b0); #1;
    chk("b2b_stallCnt", stallCntA, 6);

    // ---- saturation at 4 bits ----
    clearStats();
    for (int c = 0; c < 20; c++) begin
      drive(vecA[6], 1'b0);
      @(negedge clk);
    end
    drive(idleV, 1'b0); #1;
    chk("sat_stallCnt", stallCntA, 15);

    // ---- reset in the middle of a wait ----
    @(negedge clk); drive(idleV, 1'b1);
    @(negedge clk); v = mk(0,0,0,0, 5,0,0,0,0, 5,1, 0,0, 0, 0, 0,0); drive(v, 1'b0); #1;
    chk("rw_inWait", ifA.stallF, 1);
    rst = 1'b0; #1;
    chk("rw_flags", flagsA(), 0);
    chk("rw_fwdA", ifA.forwardAE, 0);
    chk("rw_stallCnt", stallCntA, 0);
    @(negedge clk); rst = 1'b1; #1;
    chk("rw_idle", ifA.stallF, 0);
    chk("rw_fwdBack", ifA.forwardAE, 2);
    begin
      int n = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk); drive(idleV, c == 0); #1;
        if (ifA.stallF) n++;
      end
      chk("rw_freshWait", n, 3);
    end

    // ---- stall-on-RAW instance ----
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); drive(vecB[i], 1'b0); #1;
      chk($sformatf("B%0d_flags", i), flagsB(), vecB[i].flags);
      chk($sformatf("B%0d_fwd", i), {ifB.forwardAE, ifB.forwardBE}, 0);
    end

    // ---- MEM_LAT=2: one stall per access, then the same access completes ----
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); drive(idleV, 1'b1); #1;
      chk($sformatf("m2_%0d_stallF", c), ifB.stallF, (c % 2) == 0);
      chk($sformatf("m2_%0d_flushW", c), ifB.flushW, (c % 2) == 0);
    end
    @(negedge clk); drive(idleV, 1'b0); #1;
    // 1 (post-reset pulse) + 3 (table RAW stalls) + 2 (accesses above)
    chk("B_stallCnt", stallCntB, 6);
    chk("B_flushCnt", flushCntB, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
